// File: rtl/sw_cond_pkg.sv
// sw_cond_pkg: shared debounce FSM state type and default settle time
package sw_cond_pkg;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 1000000;
  typedef enum logic [1:0] {STABLE_LO, WAIT_HI, STABLE_HI, WAIT_LO} deb_state_t;
endpackage

// File: rtl/sw_debounce_bit.sv
// sw_debounce_bit: two-flop synchronizer plus settle-time FSM for one switch pin
module sw_debounce_bit
  import sw_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sw_in,
  output logic level,
  output logic upd
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  logic s1, s2;
  logic [CW-1:0] cnt;
  deb_state_t state;
  // level toggles on the coming edge; lets the parent register its strobes in step with level
  assign upd = (state == WAIT_HI && s2 && cnt == LAST) || (state == WAIT_LO && !s2 && cnt == LAST);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      state <= STABLE_LO;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      s1 <= sw_in;
      s2 <= s1;
      case (state)
        STABLE_LO: if (s2) begin state <= WAIT_HI; cnt <= '0; end
        WAIT_HI:
          if (!s2) begin state <= STABLE_LO; cnt <= '0; end
          else if (cnt == LAST) begin state <= STABLE_HI; cnt <= '0; level <= 1'b1; end
          else cnt <= cnt + 1'b1;
        STABLE_HI: if (!s2) begin state <= WAIT_LO; cnt <= '0; end
        WAIT_LO:
          if (s2) begin state <= STABLE_HI; cnt <= '0; end
          else if (cnt == LAST) begin state <= STABLE_LO; cnt <= '0; level <= 1'b0; end
          else cnt <= cnt + 1'b1;
        default: begin state <= STABLE_LO; cnt <= '0; end
      endcase
    end
  end
endmodule

// File: rtl/sw_conditioner.sv
// sw_conditioner: per-bit switch debouncer with change strobe; SW_EDGE_PULSE_EN adds rise/fall pulses
module sw_conditioner
  import sw_cond_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw_in,
  output logic [WIDTH-1:0] sw_out,
  output logic             changed
`ifdef SW_EDGE_PULSE_EN
  ,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
`endif
);
  logic [WIDTH-1:0] upd;
  if (DEBOUNCE_CYCLES < 2) begin : g_bad_cfg
    $error("sw_conditioner: DEBOUNCE_CYCLES must be at least 2");
  end
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    sw_debounce_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_bit (
      .clk   (clk),
      .rst_n (rst_n),
      .sw_in (sw_in[i]),
      .level (sw_out[i]),
      .upd   (upd[i])
    );
  end
`ifdef SW_EDGE_PULSE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      changed <= 1'b0;
      rise    <= '0;
      fall    <= '0;
    end else begin
      changed <= |upd;
      rise    <= upd & ~sw_out;
      fall    <= upd & sw_out;
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) changed <= 1'b0;
    else changed <= |upd;
  end
`endif
endmodule

// File: tb/tb_sw_conditioner.sv
// tb_sw_conditioner: randomized and directed checks against a run-length debounce model
module tb_sw_conditioner;
  localparam int W = 4;
  localparam int D = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [W-1:0] sw_in = '0;
  logic [W-1:0] sw_out;
  logic changed;
`ifdef SW_EDGE_PULSE_EN
  logic [W-1:0] rise, fall;
`endif
  int n_checks = 0;
  int n_fail = 0;
  logic [W-1:0] m_p1, m_p2, m_prev, m_out, m_rise, m_fall;
  logic m_changed;
  int m_run [W];

  sw_conditioner #(.WIDTH(W), .DEBOUNCE_CYCLES(D)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .sw_in   (sw_in),
    .sw_out  (sw_out),
    .changed (changed)
`ifdef SW_EDGE_PULSE_EN
    ,
    .rise    (rise),
    .fall    (fall)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_p1 = '0; m_p2 = '0; m_prev = '0; m_out = '0;
    m_rise = '0; m_fall = '0; m_changed = 1'b0;
    for (int b = 0; b < W; b++) m_run[b] = 0;
  endtask

  // A level is accepted once the synchronized pin has shown it on D+1 consecutive edges
  task automatic model_edge(input logic [W-1:0] pin);
    logic [W-1:0] fin;
    fin = m_p2; m_p2 = m_p1; m_p1 = pin;
    m_rise = '0; m_fall = '0;
    for (int b = 0; b < W; b++) begin
      m_run[b] = (fin[b] == m_prev[b]) ? m_run[b] + 1 : 1;
      if (m_run[b] >= D + 1 && fin[b] != m_out[b]) begin
        if (fin[b]) m_rise[b] = 1'b1; else m_fall[b] = 1'b1;
        m_out[b] = fin[b];
      end
    end
    m_prev = fin;
    m_changed = |(m_rise | m_fall);
  endtask

  task automatic compare_all(input string tag);
    check({tag, "_sw_out"}, 32'(sw_out), 32'(m_out));
    check({tag, "_changed"}, 32'(changed), 32'(m_changed));
`ifdef SW_EDGE_PULSE_EN
    check({tag, "_rise"}, 32'(rise), 32'(m_rise));
    check({tag, "_fall"}, 32'(fall), 32'(m_fall));
`endif
  endtask

  task automatic step(input logic [W-1:0] v, input string tag);
    sw_in = v;
    @(posedge clk);
    model_edge(v);
    #1;
    compare_all(tag);
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_sw_out", 32'(sw_out), 32'h0);
    check("reset_changed", 32'(changed), 32'h0);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) step(4'b0000, "idle");
    for (int i = 0; i < 3; i++) step(4'b0001, "glitch_hi");
    for (int i = 0; i < 10; i++) begin
      step(4'b0000, "glitch_lo");
      check("glitch_hold", 32'(sw_out), 32'h0);
    end
    for (int i = 1; i <= 10; i++) begin
      step(4'b0001, "rise0");
      if (i == 6) check("lat_e6", 32'(sw_out), 32'h0);
      if (i == 7) begin
        check("lat_e7", 32'(sw_out), 32'h1);
        check("lat_e7_changed", 32'(changed), 32'h1);
      end
      if (i == 8) check("lat_e8_changed", 32'(changed), 32'h0);
    end
    for (int i = 0; i < 10; i++) step(4'b0000, "back0");
    for (int i = 1; i <= 9; i++) begin
      step(4'b0101, "multi");
      if (i == 7) begin
        check("multi_e7", 32'(sw_out), 32'h5);
        check("multi_e7_changed", 32'(changed), 32'h1);
`ifdef SW_EDGE_PULSE_EN
        check("multi_e7_rise", 32'(rise), 32'h5);
`endif
      end
    end
    for (int i = 0; i < 10; i++) step(4'b0000, "back0b");
    for (int i = 1; i <= 4; i++) step(4'b0001, "pre_rst");
    rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_mid_sw_out", 32'(sw_out), 32'h0);
    check("rst_mid_changed", 32'(changed), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      step(4'b0001, "post_rst");
      if (i == 6) check("post_rst_e6", 32'(sw_out), 32'h0);
      if (i == 7) check("post_rst_e7", 32'(sw_out), 32'h1);
    end
    for (int i = 0; i < 10; i++) step(4'b1111, "all_hi");
    check("all_hi_level", 32'(sw_out), 32'hF);
    for (int i = 0; i < 20; i++) begin
      step((i % 3 == 2) ? 4'b1111 : 4'b0000, "bounce");
      check("bounce_hold", 32'(sw_out), 32'hF);
    end
    for (int i = 1; i <= 8; i++) begin
      step(4'b0000, "settle");
      if (i == 4) check("settle_e4", 32'(sw_out), 32'hF);
      if (i == 5) check("settle_e5", 32'(sw_out), 32'h0);
    end
    begin
      logic [W-1:0] cur;
      cur = '0;
      for (int i = 0; i < 600; i++) begin
        if ($urandom_range(0, 3) == 0) cur = cur ^ W'($urandom);
        step(cur, "rand");
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
